conv3x3_filter: RTL and testbench
=================================

CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Parameters
REQ-001 SHALL have parameter PIX_W, default 8, meaning the pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, meaning the output pixels per row.
REQ-003 SHALL have parameter IMG_H, default 64, meaning the output rows per frame.

Interface
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: window pixels valid this cycle.
REQ-007 SHALL have ports p1..p9, input, PIX_W each, unsigned: 3x3 window, row-major (p1 top-left, p5 centre, p9 bottom-right).
REQ-008 SHALL have port coef_wr, input, 1 bit: coefficient write strobe.
REQ-009 SHALL have port coef_addr, input, 4 bits: coefficient index 0..8, mapping to p1..p9.
REQ-010 SHALL have port coef_data, input, 8 bits: signed two's-complement coefficient.
REQ-011 SHALL have port shift, input, 4 bits: normalisation right-shift amount, quasi-static.
REQ-012 SHALL have port out_valid, output, 1 bit: pixel_out valid.
REQ-013 SHALL have port pixel_out, output, PIX_W: filtered, saturated pixel.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last pixel of a frame.
REQ-015 SHALL have port row_done, output, 1 bit: one-cycle pulse coincident with the last pixel of a row.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 registers the nine products, S2 registers the 21-bit signed sum, S3 registers the shifted and saturated result.
REQ-017 SHALL assert out_valid exactly 3 cycles after the in_valid that produced it; the valid bit SHALL travel with the data and there SHALL be no stall or backpressure.
REQ-018 SHALL zero-extend each pixel to 9-bit signed and multiply it by its coefficient, giving a 17-bit signed product.
REQ-019 SHALL sign-extend the products to 21 bits before summing, so the sum cannot overflow.
REQ-020 SHALL arithmetic-right-shift the sum by shift (floor toward minus infinity), then clamp below 0 to 0 and above 2^PIX_W-1 to 2^PIX_W-1.
REQ-021 SHALL update coefficient[coef_addr] with coef_data at the clock edge where coef_wr=1.
REQ-022 SHALL ignore a coef_wr with coef_addr greater than 8 (no register changes).
REQ-023 SHALL use the old coefficient for a window accepted on the same edge as a coef_wr; the new coefficient applies from the next accepted window.
REQ-024 SHALL keep a column counter in 0..IMG_W-1 and a row counter in 0..IMG_H-1, both advancing on each out_valid.
REQ-025 SHALL wrap the column counter to 0 at IMG_W-1 and increment the row counter at that point.
REQ-026 SHALL pulse row_done with the output at column IMG_W-1.
REQ-027 SHALL pulse frame_done (together with row_done) with the output at row IMG_H-1, column IMG_W-1, and SHALL then wrap both counters to 0.
REQ-028 SHALL hold pixel_out at its last value when out_valid=0, and the counters SHALL not move.
REQ-029 SHALL accept back-to-back in_valid at full rate, one window per cycle.

Reset
REQ-030 SHALL, on asserted rst (asynchronous), clear out_valid, pixel_out, row_done, frame_done, all pipeline valid bits and both counters to 0.
REQ-031 SHALL reset the coefficients to the identity kernel: coefficient 4 = +1, all others 0.
REQ-032 SHALL discard any windows in flight when rst is asserted mid-pipeline and SHALL produce no out_valid for them after release.
REQ-033 SHALL accept a new in_valid on the first rising edge after rst deasserts.

Structure
REQ-034 SHALL take PIX_W, the coefficient width (8), the sum width (21), the tap count (9) and the default identity-kernel constant from the shared image-processing package.
REQ-035 SHALL use one sub-module, conv_sat_shift, that performs the S3 shift and clamp combinationally; it is reusable by the other filter stages.

Verification
REQ-036 SHALL cover: after reset, one window with p5=200 and all others 0 -> pixel_out=200 with out_valid exactly 3 cycles later.
REQ-037 SHALL cover: all nine coefficients = 1, shift=3, all pixels 255 -> sum 2295, shifted 286, pixel_out=255 (saturated high).
REQ-038 SHALL cover: Laplacian kernel (centre +4, edge-adjacent -1, corners 0), shift=0, p5=0 with neighbours 100 -> pixel_out=0 (saturated low); the same kernel with p5=100 and neighbours 10 -> pixel_out=255; with p5=60 and neighbours 50 -> pixel_out=40.
REQ-039 SHALL cover: coef_wr addr=4 data=2 on the same edge as in_valid (p5=50) -> that output is 50 and the next identical window gives 100; coef_wr with addr=9 changes nothing.
REQ-040 SHALL cover: 4096 consecutive in_valid cycles -> 64 row_done pulses and exactly one frame_done, on output 4096; the counters are back at 0.
REQ-041 SHALL cover: rst asserted for one cycle while 2 windows are in flight -> no out_valid for them, and a window applied right after release emerges 3 cycles later.

Source files
------------

// File: rtl/conv3x3_filter_pkg.sv
// Shared image-processing constants for the 3x3 filter family.
// Provides the default pixel width, coefficient width, accumulator width,
// tap count and the identity kernel loaded into the coefficients on reset.
package conv3x3_filter_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int COEF_W     = 8;
  localparam int SUM_W      = 21;
  localparam int N_TAPS     = 9;
  localparam int CENTER_TAP = 4;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Identity kernel packed tap 0 in the low byte: only the centre tap is +1.
  localparam logic [N_TAPS*COEF_W-1:0] IDENTITY_KERNEL =
    (N_TAPS*COEF_W)'(1) << (CENTER_TAP*COEF_W);

  function automatic coef_t default_coef(input int tap);
    return $signed(IDENTITY_KERNEL[tap*COEF_W +: COEF_W]);
  endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// Arithmetic right shift and saturation of a signed accumulator down to an
// unsigned pixel. Purely combinational so the caller decides where to register.
//   sum_in  : signed accumulator
//   shift   : right-shift amount (floor toward minus infinity)
//   pix_out : result clamped to 0 .. 2^PIX_W-1
module conv_sat_shift
  import conv3x3_filter_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ACC_W  = SUM_W
) (
  input  logic signed [ACC_W-1:0] sum_in,
  input  logic        [3:0]       shift,
  output logic        [PIX_W-1:0] pix_out
);

  localparam logic signed [ACC_W-1:0] PIX_MAX =
    $signed({{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}});

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum_in >>> shift;
    pix_out = '0;
    if (shifted < 0) begin
      pix_out = '0;
    end else if (shifted > PIX_MAX) begin
      pix_out = '1;
    end else begin
      pix_out = shifted[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// Programmable 3x3 convolution with a 3-stage pipeline and frame tracking.
//   clk, rst        : clock and asynchronous active-high reset
//   in_valid, p1-p9 : window pixels, row-major, p5 is the centre
//   coef_*          : coefficient write port (index 0..8 maps to p1..p9)
//   shift           : normalisation right shift, expected to be quasi-static
//   out_valid       : pixel_out valid, 3 cycles after the producing in_valid
//   pixel_out       : filtered, saturated pixel (holds when out_valid=0)
//   row_done        : pulse with the last pixel of each row
//   frame_done      : pulse with the last pixel of each frame
module conv3x3_filter
  import conv3x3_filter_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  input  logic             coef_wr,
  input  logic [3:0]       coef_addr,
  input  logic [7:0]       coef_data,
  input  logic [3:0]       shift,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic             frame_done,
  output logic             row_done
);

  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [PIX_W-1:0] pix [N_TAPS];

  assign pix[0] = p1;
  assign pix[1] = p2;
  assign pix[2] = p3;
  assign pix[3] = p4;
  assign pix[4] = p5;
  assign pix[5] = p6;
  assign pix[6] = p7;
  assign pix[7] = p8;
  assign pix[8] = p9;

  coef_t                     coef_d [N_TAPS];
  coef_t                     coef_q [N_TAPS];
  logic signed [PROD_W-1:0]  prod_d [N_TAPS];
  logic signed [PROD_W-1:0]  prod_q [N_TAPS];
  logic                      s1_valid_d, s1_valid_q;
  logic signed [SUM_W-1:0]   sum_d, sum_q;
  logic                      s2_valid_d, s2_valid_q;
  logic [PIX_W-1:0]          sat_pix;
  logic [PIX_W-1:0]          pixel_out_d, pixel_out_q;
  logic                      out_valid_d, out_valid_q;
  logic                      row_done_d, row_done_q;
  logic                      frame_done_d, frame_done_q;
  logic [COL_W-1:0]          col_d, col_q;
  logic [ROW_W-1:0]          row_d, row_q;

  // Out-of-range addresses match no tap and so leave every coefficient alone.
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      coef_d[i] = coef_q[i];
      if (coef_wr && (coef_addr == 4'(i))) begin
        coef_d[i] = $signed(coef_data);
      end
    end
  end

  // Products use coef_q, so a window sharing an edge with a write sees the
  // old coefficient. The pixel gets a zero sign bit before the signed multiply.
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(coef_q[i]);
    end
    s1_valid_d = in_valid;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
    s2_valid_d = s1_valid_q;
  end

  conv_sat_shift #(
    .PIX_W (PIX_W),
    .ACC_W (SUM_W)
  ) u_sat (
    .sum_in  (sum_q),
    .shift   (shift),
    .pix_out (sat_pix)
  );

  // Counters hold the position of the next pixel to leave the pipeline.
  always_comb begin
    out_valid_d  = s2_valid_q;
    pixel_out_d  = pixel_out_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    col_d        = col_q;
    row_d        = row_q;
    if (s2_valid_q) begin
      pixel_out_d = sat_pix;
      if (col_q == COL_MAX) begin
        col_d      = '0;
        row_done_d = 1'b1;
        if (row_q == ROW_MAX) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= default_coef(i);
        prod_q[i] <= '0;
      end
      s1_valid_q   <= 1'b0;
      sum_q        <= '0;
      s2_valid_q   <= 1'b0;
      pixel_out_q  <= '0;
      out_valid_q  <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= coef_d[i];
        prod_q[i] <= prod_d[i];
      end
      s1_valid_q   <= s1_valid_d;
      sum_q        <= sum_d;
      s2_valid_q   <= s2_valid_d;
      pixel_out_q  <= pixel_out_d;
      out_valid_q  <= out_valid_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign pixel_out  = pixel_out_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
module tb_conv3x3_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] p_arr [9];
  logic       coef_wr;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic [3:0] shift;
  logic       out_valid;
  logic [7:0] pixel_out;
  logic       frame_done;
  logic       row_done;

  int errors = 0;
  int checks = 0;
  int coef_m [9];
  int shift_m;

  always #5 clk = ~clk;

  conv3x3_filter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .p1         (p_arr[0]),
    .p2         (p_arr[1]),
    .p3         (p_arr[2]),
    .p4         (p_arr[3]),
    .p5         (p_arr[4]),
    .p6         (p_arr[5]),
    .p7         (p_arr[6]),
    .p8         (p_arr[7]),
    .p9         (p_arr[8]),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .shift      (shift),
    .out_valid  (out_valid),
    .pixel_out  (pixel_out),
    .frame_done (frame_done),
    .row_done   (row_done)
  );

  // Reference: dot product, floor division by 2^shift, clamp to 0..255.
  function automatic int model(input int pix [9]);
    int s = 0;
    for (int i = 0; i < 9; i++) s += pix[i] * coef_m[i];
    s = s >>> shift_m;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < 9; i++) coef_m[i] = (i == 4) ? 1 : 0;
  endtask

  task automatic drive(input int pix [9], input bit v);
    for (int i = 0; i < 9; i++) p_arr[i] = 8'(pix[i]);
    in_valid = v;
  endtask

  task automatic set_shift(input int s);
    shift   = 4'(s);
    shift_m = s;
  endtask

  task automatic set_coef(input int a, input int d);
    logic [7:0] d8;
    d8 = 8'(d);
    @(negedge clk);
    coef_wr = 1'b1; coef_addr = 4'(a); coef_data = d8;
    @(negedge clk);
    coef_wr = 1'b0;
    if (a < 9) coef_m[a] = int'($signed(d8));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_identity();
  endtask

  // Sends one window (optionally with a coefficient write on the same edge)
  // and returns out_valid seen on the next three cycles plus the final pixel.
  task automatic run_window(input int pix [9], input bit cw, input int ca, input int cd,
                            output bit [2:0] vseq, output int pix_obs);
    @(negedge clk);
    drive(pix, 1'b1);
    coef_wr = cw; coef_addr = 4'(ca); coef_data = 8'(cd);
    @(negedge clk);
    vseq[2] = out_valid; in_valid = 1'b0; coef_wr = 1'b0;
    @(negedge clk);
    vseq[1] = out_valid;
    @(negedge clk);
    vseq[0] = out_valid;
    pix_obs = int'(pixel_out);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    set_shift(0);
    for (int i = 0; i < 9; i++) p_arr[i] = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out got=%0d want=0", pixel_out); end
    checks++; if (row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done got=%b want=0", row_done); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    rst = 1'b0;
    model_identity();
  endtask

  task automatic test_identity();
    int pix [9] = '{0, 0, 0, 0, 200, 0, 0, 0, 0};
    bit [2:0] v; int got;
    set_shift(0);
    run_window(pix, 1'b0, 0, 0, v, got);
    checks++; if (v !== 3'b001) begin errors++; $display("FAIL identity_latency got=%b want=001", v); end
    checks++; if (got !== 200) begin errors++; $display("FAIL identity_pixel got=%0d want=200", got); end
  endtask

  task automatic test_saturate_high();
    int pix [9] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    bit [2:0] v; int got;
    for (int i = 0; i < 9; i++) set_coef(i, 1);
    set_shift(3);
    run_window(pix, 1'b0, 0, 0, v, got);
    checks++; if (v !== 3'b001) begin errors++; $display("FAIL sat_high_latency got=%b want=001", v); end
    checks++; if (got !== 255) begin errors++; $display("FAIL sat_high_pixel got=%0d want=255", got); end
  endtask

  task automatic test_laplacian();
    int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int centre [3] = '{0, 100, 60};
    int nb [3]     = '{100, 10, 50};
    int want [3]   = '{0, 255, 40};
    int pix [9];
    bit [2:0] v; int got;
    for (int i = 0; i < 9; i++) set_coef(i, lap[i]);
    set_shift(0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++) pix[i] = (i == 4) ? centre[k] : nb[k];
      run_window(pix, 1'b0, 0, 0, v, got);
      checks++; if (v !== 3'b001) begin errors++; $display("FAIL laplacian_latency case=%0d got=%b want=001", k, v); end
      checks++; if (got !== want[k]) begin errors++; $display("FAIL laplacian_pixel case=%0d got=%0d want=%0d", k, got, want[k]); end
    end
  endtask

  task automatic test_coef_same_edge();
    int pix [9] = '{0, 0, 0, 0, 50, 0, 0, 0, 0};
    int flat [9] = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    bit [2:0] v; int got; int exp_v;
    for (int i = 0; i < 9; i++) set_coef(i, (i == 4) ? 1 : 0);
    set_shift(0);
    run_window(pix, 1'b1, 4, 2, v, got);
    checks++; if (got !== 50) begin errors++; $display("FAIL coef_old_on_same_edge got=%0d want=50", got); end
    coef_m[4] = 2;
    run_window(pix, 1'b0, 0, 0, v, got);
    checks++; if (got !== 100) begin errors++; $display("FAIL coef_new_next_window got=%0d want=100", got); end
    run_window(flat, 1'b1, 9, 8'h7f, v, got);
    exp_v = model(flat);
    checks++; if (got !== exp_v) begin errors++; $display("FAIL coef_addr9_same got=%0d want=%0d", got, exp_v); end
    run_window(flat, 1'b1, 15, 8'h80, v, got);
    checks++; if (got !== exp_v) begin errors++; $display("FAIL coef_addr15_same got=%0d want=%0d", got, exp_v); end
    run_window(flat, 1'b0, 0, 0, v, got);
    checks++; if (got !== exp_v) begin errors++; $display("FAIL coef_bad_addr_after got=%0d want=%0d", got, exp_v); end
  endtask

  task automatic test_random();
    int pix [9];
    bit [2:0] v; int got; int exp_v;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 9; i++) set_coef(i, int'($urandom_range(0, 255)));
      set_shift((n % 6 == 5) ? 15 : int'($urandom_range(0, 6)));
      for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
      run_window(pix, 1'b0, 0, 0, v, got);
      exp_v = model(pix);
      checks++; if (v !== 3'b001) begin errors++; $display("FAIL random_latency n=%0d got=%b want=001", n, v); end
      checks++; if (got !== exp_v) begin errors++; $display("FAIL random_pixel n=%0d got=%0d want=%0d", n, got, exp_v); end
    end
  endtask

  // Full frame plus one extra row, back to back, from a fresh reset.
  task automatic test_back_to_back_frame();
    int expq [$];
    int pix [9];
    int total = 4096 + 64;
    int outs = 0, rows = 0, frames = 0, frame_at = -1;
    int e;
    bit exp_v;
    apply_reset();
    for (int i = 0; i < 9; i++) set_coef(i, int'($urandom_range(0, 3)));
    set_shift(2);
    for (int cyc = 0; cyc < total + 3; cyc++) begin
      @(negedge clk);
      exp_v = (cyc >= 3);
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v); end
      if (out_valid === 1'b1) begin
        outs++;
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        checks++; if (int'(pixel_out) !== e) begin errors++; $display("FAIL stream_pixel out=%0d got=%0d want=%0d", outs, pixel_out, e); end
        checks++; if (row_done !== (outs % 64 == 0)) begin errors++; $display("FAIL stream_row_done out=%0d got=%b", outs, row_done); end
        checks++; if (frame_done !== (outs == 4096)) begin errors++; $display("FAIL stream_frame_done out=%0d got=%b", outs, frame_done); end
        if (row_done === 1'b1) rows++;
        if (frame_done === 1'b1) begin frames++; frame_at = outs; end
      end
      if (cyc < total) begin
        for (int i = 0; i < 9; i++) pix[i] = int'($urandom_range(0, 255));
        drive(pix, 1'b1);
        expq.push_back(model(pix));
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (rows !== 65) begin errors++; $display("FAIL frame_row_count got=%0d want=65", rows); end
    checks++; if (frames !== 1) begin errors++; $display("FAIL frame_count got=%0d want=1", frames); end
    checks++; if (frame_at !== 4096) begin errors++; $display("FAIL frame_position got=%0d want=4096", frame_at); end
  endtask

  task automatic test_reset_mid_flight();
    int w1 [9] = '{0, 0, 0, 0, 11, 0, 0, 0, 0};
    int w2 [9] = '{0, 0, 0, 0, 22, 0, 0, 0, 0};
    int w3 [9] = '{0, 0, 0, 0, 77, 0, 0, 0, 0};
    bit [2:0] v;
    set_shift(0);
    @(negedge clk); drive(w1, 1'b1);
    @(negedge clk); drive(w2, 1'b1);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_during got=%b want=0", out_valid); end
    @(negedge clk); rst = 1'b0; model_identity(); drive(w3, 1'b1);
    @(negedge clk); v[2] = out_valid; in_valid = 1'b0;
    @(negedge clk); v[1] = out_valid;
    @(negedge clk); v[0] = out_valid;
    checks++; if (v !== 3'b001) begin errors++; $display("FAIL midrst_latency got=%b want=001", v); end
    checks++; if (pixel_out !== 8'(model(w3))) begin errors++; $display("FAIL midrst_pixel got=%0d want=%0d", pixel_out, model(w3)); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost k=%0d got=%b want=0", k, out_valid); end
      checks++; if (pixel_out !== 8'd77) begin errors++; $display("FAIL midrst_hold k=%0d got=%0d want=77", k, pixel_out); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturate_high();
    test_laplacian();
    test_coef_same_edge();
    test_random();
    test_back_to_back_frame();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
